// File: rtl/frame_buf_writer.sv
// frame_buf_writer: write-side master for the frame buffer RAM.
// Accepts a valid/ready byte stream and issues one registered RAM write
// per accepted byte, DEPTH bytes per frame starting at BASE_ADDR.
module frame_buf_writer #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16384,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_W_EN,
  output logic [ADDR_W-1:0] o_W_ADDR,
  output logic [DATA_W-1:0] o_W_DATA,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count,
  output logic              o_drop
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  // Index of the last byte of a frame; cnt is one bit wider than the
  // address so a full 2^ADDR_W frame count is representable.
  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt;
  logic              accept;
  logic              start_ok;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              drop;

  // Handshake decodes come from registered state only.
  assign o_ready  = (state == WRITE);
  assign o_busy   = (state != IDLE);
  assign o_done   = (state == DONE);
  assign accept   = i_valid & o_ready;
  assign start_ok = (state == IDLE) & i_start;

  assign o_W_EN   = wen;
  assign o_W_ADDR = waddr;
  assign o_W_DATA = wdata;
  assign o_count  = cnt;
  assign o_drop   = drop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start only from IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = WRITE;
      WRITE:   if (accept && cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte counter: cleared by an accepted start, held after the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (start_ok) cnt <= '0;
    else if (accept)   cnt <= cnt + 1'b1;
  end

  // Sticky drop flag; an accepted start takes priority over a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   drop <= 1'b0;
    else if (start_ok)            drop <= 1'b0;
    else if (i_valid && !o_ready) drop <= 1'b1;
  end

  // One-stage write pipeline; address/data hold while no write is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wen <= accept;
      if (accept) begin
        waddr <= BASE + cnt[ADDR_W-1:0];
        wdata <= i_data;
      end
    end
  end

endmodule

// File: doc/frame_buf_writer.md
Name: frame_buf_writer

Overview:
- Write-side master for the 16K x 8 frame buffer. The existing read path fetches pixels from this buffer and re-aligns the read address and data.
- Accepts a pixel byte stream on a valid/ready handshake. Generates one write strobe, write address and write data per accepted byte.
- Writes exactly DEPTH bytes per frame, starting at BASE_ADDR, then signals completion.
- Sits between the pixel source and the write port of the buffer RAM.

Parameters:
ADDR_W, 14, buffer address width.
DATA_W, 8, pixel/data width.
DEPTH, 16384, bytes per frame; legal range 1..2^ADDR_W.
BASE_ADDR, 0, first write address of each frame.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
i_start  in  1  frame start request, sampled in IDLE only.
i_valid  in  1  input byte valid.
i_data  in  DATA_W  input byte.
o_ready  out  1  block accepts a byte this cycle.
o_W_EN  out  1  RAM write strobe.
o_W_ADDR  out  ADDR_W  RAM write address.
o_W_DATA  out  DATA_W  RAM write data.
o_busy  out  1  frame in progress (state != IDLE).
o_done  out  1  single-cycle frame-complete pulse.
o_count  out  ADDR_W+1  bytes accepted in the current/last frame.
o_drop  out  1  sticky: a byte was offered while o_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; internal counter cnt = 0.
  - All outputs = 0, including o_W_ADDR, o_W_DATA, o_count and o_drop.
  - Reset asserted mid-frame aborts the frame immediately; no further strobes are issued.
- States:
  - IDLE: o_ready=0. i_start=1 moves to WRITE next cycle. cnt, o_count and o_drop clear on that edge.
  - WRITE: o_ready=1. A byte is accepted when i_valid & o_ready.
    - On accept: cnt increments.
    - If the accepted byte is the one with cnt==DEPTH-1, the state moves to DONE on the next edge.
  - DONE: exactly one cycle. o_ready=0, o_done=1. Then return to IDLE.
- o_ready is a decode of the registered state only; it has no combinational path from i_valid.
- Write pipeline (1-cycle latency): a byte accepted at edge k produces, during cycle k+1:
  - o_W_EN=1
  - o_W_ADDR=(BASE_ADDR+cnt_at_accept) mod 2^ADDR_W
  - o_W_DATA=i_data as accepted
- The final write strobe of a frame coincides with the o_done cycle.
- o_W_EN=0 in every cycle without a preceding accept. o_W_ADDR and o_W_DATA hold their last values while o_W_EN=0.
- Address wraps modulo 2^ADDR_W. Example: BASE_ADDR=16382, DEPTH=4 writes 16382, 16383, 0, 1.
- o_count = cnt, registered, ADDR_W+1 bits wide so DEPTH=2^ADDR_W is representable. It holds its final value after DONE until the next accepted start.
- i_start is ignored in WRITE and DONE; it is not queued. A held i_start starts a new frame on the first IDLE cycle.
- i_valid=1 while o_ready=0 (IDLE or DONE): the byte is discarded, no write occurs, and o_drop is set. o_drop clears only on reset or an accepted start.
- Gaps (i_valid=0) during WRITE produce no strobes and do not advance the address; there is no timeout.

Test Plan:
1. Defaults: pulse i_start at cycle 0, then i_valid=1 continuously with i_data=cnt[7:0].
   -> o_ready=1 from cycle 1; 16384 consecutive strobes at addresses 0..16383 with data 0x00..0xFF repeating.
   -> o_done=1 only in the cycle of the write to address 16383; o_count=16384; o_busy=0 the next cycle.
2. DEPTH=4, BASE_ADDR=16382: bytes 0xA0, 0xA1, 0xA2, 0xA3 with i_valid low for 2 cycles between beats.
   -> exactly 4 strobes, (16382,0xA0), (16383,0xA1), (0,0xA2), (1,0xA3), each 1 cycle after its accept; no strobe during gaps.
3. Drop: in IDLE drive i_valid=1, i_data=0x55 for 1 cycle -> no o_W_EN, o_drop=1 and held; then i_start -> o_drop=0 next cycle.
4. DEPTH=4: assert i_start again after 2 accepted bytes -> ignored; 3rd byte goes to BASE_ADDR+2; one o_done only.
5. DEPTH=4: drop rst_n mid-cycle after 2 accepted bytes.
   -> outputs 0 immediately, no further strobes.
   -> a new start writes from BASE_ADDR and o_count restarts at 0.
6. DEPTH=1: start and one byte 0x7E -> single strobe (BASE_ADDR, 0x7E) with o_done in the same cycle; IDLE the next cycle.
